led_breathe: RTL
================

Name: led_breathe

Overview:
- Downstream consumer of the blink stage's square-wave LED toggle.
- Turns each toggle edge into a smooth brightness ramp (fade in on rising, fade out on falling).
- Drives the physical LED pin with a PWM waveform at the ramp's current brightness level.
- Sits between the blink counter and the board LED, in the same clk50m domain.

Parameters:
- PWM_BITS, 8: width of the brightness level and PWM counter; MAX = 2**PWM_BITS-1.
- STEP_CYCLES, 49020: clk50m cycles per one-LSB level step. A full 0→255 ramp takes about 0.25 s at 50 MHz. Must be ≥1.

Ports:
- clk50m  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous active-low reset.
- led_in  input  1  toggle from the upstream blink stage; same clock domain.
- enable  input  1  1 = normal operation; 0 = output forced off and ramp frozen.
- pwm_out  output  1  PWM LED drive, registered.
- level  output  PWM_BITS  current brightness, registered.
- busy  output  1  high while ramping up or down.

Behaviour:
- Interface: one clock, clk50m. Reset reset_n is asynchronous and active-low.
- Reset values (asynchronous, take effect immediately):
  - state = S_OFF, level = 0, pwm_cnt = 0, step_cnt = STEP_CYCLES-1, led_q = 0.
  - pwm_out = 0, busy = 0.
- Edge detect:
  - led_q <= led_in every cycle.
  - rise = led_in & ~led_q; fall = ~led_in & led_q.
  - If led_in = 1 at reset release, the first cycle sees a rise.
- State machine (evaluated every cycle, regardless of enable):
  - S_OFF: rise → S_UP.
  - S_UP: fall → S_DOWN. Otherwise, when level reaches MAX → S_ON.
  - S_ON: fall → S_DOWN.
  - S_DOWN: rise → S_UP. Otherwise, when level reaches 0 → S_OFF.
  - Edges that match the current direction are ignored (rise in S_UP/S_ON, fall in S_DOWN/S_OFF).
  - On reversal mid-ramp, level continues from its current value; it never jumps.
- Step timer:
  - step_cnt reloads to STEP_CYCLES-1 on every transition into S_UP or S_DOWN, including reversals.
  - In a ramp state with enable = 1, it decrements each cycle.
  - When step_cnt = 0 it reloads, and level increments (S_UP) or decrements (S_DOWN).
  - level saturates at MAX and at 0; no wrap-around.
  - The transition to S_ON/S_OFF occurs in the cycle where the stepped level equals MAX/0.
  - With enable = 0, step_cnt and level hold.
- Latency:
  - led_in edge before clk edge k: state changes at edge k, busy = 1 after edge k.
  - First level step at edge k+STEP_CYCLES.
  - Full ramp from 0: MAX*STEP_CYCLES cycles.
- PWM:
  - pwm_cnt is free-running, PWM_BITS wide, wraps MAX→0. It runs regardless of enable.
  - pwm_out <= enable & ((level == MAX) | (pwm_cnt < level)).
  - Duty = level/2**PWM_BITS, except MAX gives constant high and 0 gives constant low.
  - pwm_out lags level by one cycle.
- busy = (state == S_UP) | (state == S_DOWN), registered with state.
- Simultaneous events: a reversal edge in the same cycle as a step tick takes the reversal. level does not step that cycle, and step_cnt reloads.
- Reset mid-ramp: everything returns to reset values asynchronously. No memory of prior level.

Decomposition:
- Package led_pkg holds:
  - typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} breathe_state_t;
  - localparam default PWM_BITS.
- One sub-module, led_pwm_gen, holds the free-running pwm_cnt plus comparator and output register.
  - Inputs: clk50m, reset_n, enable, level.
  - Output: pwm_out.
- led_breathe instantiates led_pwm_gen and owns the edge detect, state machine and step timer.

Test Plan (PWM_BITS = 4 so MAX = 15, STEP_CYCLES = 4):
1. Hold reset_n = 0 with led_in = 1, then release → pwm_out = 0, level = 0 and busy = 0 during reset. Rise is seen on the first cycle; busy = 1 next cycle.
2. led_in 0→1 from S_OFF → level = 1 after 4 cycles and 15 after 60 cycles. busy = 0 from that cycle, and pwm_out is constant 1 thereafter.
3. Ramp up to level 7, then drive led_in 1→0 → level holds for 3 cycles and reaches 6 on the 4th. Level reaches 0 after 28 cycles total, then state S_OFF, busy = 0, pwm_out constant 0.
4. Freeze at level 5 (enable = 1, no edges, force via a stopped ramp) → over any 16-cycle pwm_cnt period, pwm_out is high exactly 5 cycles.
5. Mid-ramp at level 9, enable = 0 for 20 cycles → pwm_out = 0 one cycle later and level stays 9. Re-enable: next step occurs after the remaining step_cnt count, and ramping resumes.
6. Mid-ramp at level 10, assert reset_n = 0 between clock edges → level = 0, pwm_out = 0 and busy = 0 immediately, without waiting for a clock edge. After release with led_in = 0, the block stays in S_OFF.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and defaults for the LED breathing stage.
package led_pkg;

  localparam int unsigned DEFAULT_PWM_BITS    = 8;
  localparam int unsigned DEFAULT_STEP_CYCLES = 49020;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_UP   = 2'd1,
    S_ON   = 2'd2,
    S_DOWN = 2'd3
  } breathe_state_t;

  // True in the two states where the level is moving.
  function automatic logic is_ramp(input breathe_state_t s);
    return (s == S_UP) || (s == S_DOWN);
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter and comparator driving the registered LED pin.
module led_pwm_gen
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEFAULT_PWM_BITS
) (
  input  logic                clk50m,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] level,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_c;

  // Full scale is forced solid-on so the top level has no one-cycle dropout.
  assign pwm_c = enable & ((level == LEVEL_MAX) | (pwm_cnt < level));

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      pwm_out <= pwm_c;
    end
  end

endmodule

// File: rtl/led_breathe.sv
// Converts blink-stage toggles into fade-in/fade-out brightness ramps and PWM drive.
module led_breathe
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS    = DEFAULT_PWM_BITS,
  parameter int unsigned STEP_CYCLES = DEFAULT_STEP_CYCLES
) (
  input  logic                clk50m,
  input  logic                reset_n,
  input  logic                led_in,
  input  logic                enable,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0]   STEP_RELOAD = STEP_W'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX   = '1;

  breathe_state_t      state, state_next;
  logic [STEP_W-1:0]   step_cnt, step_next;
  logic [PWM_BITS-1:0] level_next;
  logic                led_q;
  logic                rise_c, fall_c, tick_c;

  assign rise_c = led_in & ~led_q;
  assign fall_c = ~led_in & led_q;
  assign tick_c = (step_cnt == '0);

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_OFF;
      step_cnt <= STEP_RELOAD;
      level    <= '0;
      led_q    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      step_cnt <= step_next;
      level    <= level_next;
      led_q    <= led_in;
      busy     <= is_ramp(state_next);
    end
  end

  // Reversal edges win over a same-cycle step tick; the timer reloads on every ramp entry.
  always_comb begin
    state_next = state;
    step_next  = step_cnt;
    level_next = level;
    unique case (state)
      S_OFF: begin
        if (rise_c) begin
          state_next = S_UP;
          step_next  = STEP_RELOAD;
        end
      end
      S_UP: begin
        if (fall_c) begin
          state_next = S_DOWN;
          step_next  = STEP_RELOAD;
        end else if (enable) begin
          if (tick_c) begin
            step_next  = STEP_RELOAD;
            level_next = (level == LEVEL_MAX) ? level : level + PWM_BITS'(1);
            if (level_next == LEVEL_MAX) state_next = S_ON;
          end else begin
            step_next = step_cnt - STEP_W'(1);
          end
        end
      end
      S_ON: begin
        if (fall_c) begin
          state_next = S_DOWN;
          step_next  = STEP_RELOAD;
        end
      end
      S_DOWN: begin
        if (rise_c) begin
          state_next = S_UP;
          step_next  = STEP_RELOAD;
        end else if (enable) begin
          if (tick_c) begin
            step_next  = STEP_RELOAD;
            level_next = (level == '0) ? level : level - PWM_BITS'(1);
            if (level_next == '0) state_next = S_OFF;
          end else begin
            step_next = step_cnt - STEP_W'(1);
          end
        end
      end
      default: state_next = S_OFF;
    endcase
  end

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk50m  (clk50m),
    .reset_n (reset_n),
    .enable  (enable),
    .level   (level),
    .pwm_out (pwm_out)
  );

endmodule
